// File: rtl/coef_loader_if.sv
// Handshake, status and read-port bundle between a coefficient source and coef_loader.
interface coef_loader_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  start;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   wr_count;
    logic [DATA_WIDTH-1:0] checksum;

    // Driver side: issues start, words and read addresses.
    modport master (
        output start, wr_valid, wr_data, rd_addr,
        input  wr_ready, rd_data, busy, done, wr_count, checksum
    );

    // Loader side.
    modport slave (
        input  start, wr_valid, wr_data, rd_addr,
        output wr_ready, rd_data, busy, done, wr_count, checksum
    );
endinterface

// File: rtl/coef_loader.sv
// Coefficient loader: fills a 2**ADDR_WIDTH word array from a valid/ready stream
// after a start pulse, keeps a modulo checksum, and serves a 1-cycle registered read port.
module coef_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    coef_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;

    // start has priority over a coincident handshake, so the word is dropped.
    assign wr_fire = bus.wr_valid & ready_q & ~bus.start;
    assign wr_addr = count_q[ADDR_WIDTH-1:0];

    // Control FSM with registered status outputs, count and checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            sum_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.start) begin
            state_q <= S_LOAD;
            count_q <= '0;
            sum_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.wr_valid) begin
                        count_q <= count_q + 1'b1;
                        sum_q   <= sum_q + bus.wr_data;
                        if (count_q == LAST_IDX) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold until the next start.
                end
            endcase
        end
    end

    // Coefficient array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    // Registered read port; sees the pre-write contents on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    assign bus.wr_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.wr_count = count_q;
    assign bus.checksum = sum_q;
    assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_coef_loader.sv
// Self-checking bench for coef_loader: behavioural array/counter model plus directed literals.
module tb_coef_loader;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    coef_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    coef_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_loading;
    bit            m_done;
    int            m_cnt;
    int            m_sum;
    logic [DW-1:0] m_rd;
    bit            m_rd_known;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    end

    // Model update: read old contents, then apply start or an accepted word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading  = 0;
            m_done     = 0;
            m_cnt      = 0;
            m_sum      = 0;
            m_rd       = '0;
            m_rd_known = 1;
        end else begin
            m_rd       = m_mem[bus.rd_addr];
            m_rd_known = m_known[bus.rd_addr];
            if (bus.start) begin
                m_loading = 1;
                m_done    = 0;
                m_cnt     = 0;
                m_sum     = 0;
            end else if (m_loading && bus.wr_valid) begin
                m_mem[m_cnt]   = bus.wr_data;
                m_known[m_cnt] = 1;
                m_cnt          = m_cnt + 1;
                m_sum          = (m_sum + int'(bus.wr_data)) % (2 ** DW);
                if (m_cnt == DEPTH) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("wr_ready", 32'(bus.wr_ready), 32'(m_loading));
            check("busy",     32'(bus.busy),     32'(m_loading));
            check("done",     32'(bus.done),     32'(m_done));
            check("wr_count", 32'(bus.wr_count), 32'(m_cnt));
            check("checksum", 32'(bus.checksum), 32'(m_sum));
            if (m_rd_known) check("rd_data", 32'(bus.rd_data), 32'(m_rd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic read_sweep();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_addr = AW'(i);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full load with words 1..16; done lands exactly 16 cycles after LOAD entry.
        pulse_start();
        check("load_entry_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("done_not_early", 32'(bus.done), 32'd0);
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'(i + 1);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        check("full_done",     32'(bus.done),     32'd1);
        check("full_ready",    32'(bus.wr_ready), 32'd0);
        check("full_count",    32'(bus.wr_count), 32'd16);
        check("full_checksum", 32'(bus.checksum), 32'h88);
        check("model_sum_pin", 32'(m_sum),        32'h88);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_addr = AW'(i);
            @(negedge clk);
            check("full_readback", 32'(bus.rd_data), 32'(i + 1));
        end

        // Randomised backpressure loads.
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            for (int c = 0; c < 400 && !bus.done; c++) begin
                bus.wr_valid = 1'($urandom_range(0, 1));
                bus.wr_data  = DW'($urandom_range(0, 255));
                bus.rd_addr  = AW'($urandom_range(0, DEPTH - 1));
                @(negedge clk);
            end
            bus.wr_valid = 1'b0;
            check("rand_load_done", 32'(bus.done), 32'd1);
            read_sweep();
        end

        // All-ones words: 16 * 0xFF mod 256 = 0xF0.
        pulse_start();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hFF;
        repeat (DEPTH) @(negedge clk);
        bus.wr_valid = 1'b0;
        check("ff_checksum", 32'(bus.checksum), 32'hF0);
        check("ff_done",     32'(bus.done),     32'd1);

        // Restart mid-load: the word coincident with start is dropped.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = DW'(8'h30 + i);
            @(negedge clk);
        end
        check("pre_restart_count", 32'(bus.wr_count), 32'd5);
        bus.start   = 1'b1;
        bus.wr_data = 8'hAA;
        @(negedge clk);
        bus.start = 1'b0;
        check("restart_count",    32'(bus.wr_count), 32'd0);
        check("restart_checksum", 32'(bus.checksum), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_data = DW'(8'h40 + i);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        check("restart_done", 32'(bus.done), 32'd1);
        // 16*0x40 + (0+..+15) = 1144 -> 0x78
        check("restart_checksum_final", 32'(bus.checksum), 32'h78);

        // Ignored writes in DONE.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h77;
        repeat (4) @(negedge clk);
        bus.wr_valid = 1'b0;
        check("done_ignore_count",    32'(bus.wr_count), 32'd16);
        check("done_ignore_checksum", 32'(bus.checksum), 32'h78);
        bus.rd_addr = 4'd0;
        @(negedge clk);
        check("done_ignore_addr0", 32'(bus.rd_data), 32'h40);
        read_sweep();

        // Asynchronous reset mid-load, checked before any clock edge.
        pulse_start();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h21;
        repeat (3) @(negedge clk);
        bus.wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_wr_count", 32'(bus.wr_count), 32'd0);
        check("rst_checksum", 32'(bus.checksum), 32'd0);
        check("rst_rd_data",  32'(bus.rd_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ignored writes in IDLE.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h99;
        repeat (4) @(negedge clk);
        bus.wr_valid = 1'b0;
        check("idle_ignore_count", 32'(bus.wr_count), 32'd0);
        check("idle_ignore_busy",  32'(bus.busy),     32'd0);
        bus.rd_addr = 4'd5;
        @(negedge clk);
        check("idle_ignore_addr5", 32'(bus.rd_data), 32'h45);
        read_sweep();

        // Read-before-write: address 2 holds 0x11, then is rewritten with 0x5A.
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = (i == 2) ? 8'h11 : DW'($urandom_range(0, 255));
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        pulse_start();
        bus.rd_addr  = 4'd2;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = (i == 2) ? 8'h5A : DW'($urandom_range(0, 255));
            @(negedge clk);
        end
        check("rbw_old", 32'(bus.rd_data), 32'h11);
        bus.wr_data = 8'h00;
        @(negedge clk);
        check("rbw_new", 32'(bus.rd_data), 32'h5A);
        for (int c = 0; c < 40 && !bus.done; c++) begin
            bus.wr_data = DW'($urandom_range(0, 255));
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        check("rbw_done", 32'(bus.done), 32'd1);
        read_sweep();

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
